// File: rtl/fifo_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_pkg
//  Description : Shared constants, types and helpers for the FIFO blocks.
//                Defines the push-arbiter FSM states and the default sizing
//                of the write-port arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
package fifo_pkg;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

  // Default sizing of the push arbiter
  localparam int NUM_REQ   = 2;
  localparam int DATA_W    = 8;
  localparam int MAX_BURST = 4;

  // Index width, never narrower than one bit
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int REQ_IDX_W   = idx_w(NUM_REQ);
  localparam int BURST_CNT_W = $clog2(MAX_BURST + 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    OWN  = 1'b1
  } arb_state_e;

  typedef logic [NUM_REQ-1:0]     req_vec_t;
  typedef logic [REQ_IDX_W-1:0]   req_idx_t;
  typedef logic [BURST_CNT_W-1:0] burst_cnt_t;

endpackage
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// ============================================================================
//  Module      : rr_pick
//  Description : Combinational round-robin picker. Returns the first set bit
//                of req, scanning upward from start and wrapping modulo
//                NUM_REQ.
//  Ports       : req    [NUM_REQ-1:0] - request vector
//                start  [IDX_W-1:0]   - first index to examine
//                valid                - any request present
//                winner [IDX_W-1:0]   - index of the chosen requester
//                onehot [NUM_REQ-1:0] - one-hot form of winner
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_pick
  import fifo_pkg::*;
#(
  parameter int NUM_REQ = fifo_pkg::NUM_REQ,
  parameter int IDX_W   = fifo_pkg::idx_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   start,
  output logic               valid,
  output logic [IDX_W-1:0]   winner,
  output logic [NUM_REQ-1:0] onehot
);

  logic [IDX_W-1:0] cand;

  // Scan from the farthest candidate to the nearest so the nearest hit
  // is the last one written and therefore wins.
  always_comb begin
    valid  = FALSE;
    winner = '0;
    onehot = '0;
    cand   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = IDX_W'((int'(start) + k) % NUM_REQ);
      if (req[cand]) begin
        valid        = TRUE;
        winner       = cand;
        onehot       = '0;
        onehot[cand] = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/fifo_push_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_push_arbiter
//  Description : Round-robin arbiter sharing the single FIFO write port among
//                NUM_REQ producers. A grant is sticky for up to MAX_BURST
//                accepted pushes, then rotates. Never pushes into a full FIFO.
//  Ports       : clk, rst                 - clock, sync active-high reset
//                req      [NUM_REQ-1:0]   - per-producer request
//                req_data [NUM_REQ*DATA_W-1:0] - packed producer data
//                full                     - FIFO full flag
//                push                     - FIFO write strobe
//                wdata    [DATA_W-1:0]    - FIFO write data
//                ack      [NUM_REQ-1:0]   - one-hot accept per producer
//                grant    [NUM_REQ-1:0]   - one-hot registered owner
//  Revision    : 1.0 - initial release
// ============================================================================
module fifo_push_arbiter
  import fifo_pkg::*;
#(
  parameter int NUM_REQ   = fifo_pkg::NUM_REQ,
  parameter int DATA_W    = fifo_pkg::DATA_W,
  parameter int MAX_BURST = fifo_pkg::MAX_BURST
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  input  logic                      full,
  output logic                      push,
  output logic [DATA_W-1:0]         wdata,
  output logic [NUM_REQ-1:0]        ack,
  output logic [NUM_REQ-1:0]        grant
);

  localparam int IDX_W   = idx_w(NUM_REQ);
  localparam int BURST_W = $clog2(MAX_BURST + 1);
  localparam logic [BURST_W-1:0] BURST_LAST = BURST_W'(MAX_BURST - 1);
  localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(NUM_REQ - 1);

  arb_state_e          state_q,       state_d;
  logic [NUM_REQ-1:0]  grant_q,       grant_d;
  logic [BURST_W-1:0]  burst_cnt_q,   burst_cnt_d;
  logic [IDX_W-1:0]    last_winner_q, last_winner_d;

  logic [IDX_W-1:0]    pick_start;
  logic                pick_valid;
  logic [IDX_W-1:0]    pick_idx;
  logic [NUM_REQ-1:0]  pick_onehot;
  logic                owner_req;
  logic                release_own;

  // Accept only when the FIFO has room; reset suppresses the stale grant so
  // nothing is written during the reset cycle.
  always_comb begin
    ack = grant_q & req & {NUM_REQ{~full}} & {NUM_REQ{~rst}};
    push = |ack;
    wdata = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (ack[i]) begin
        wdata = wdata | req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  assign grant = grant_q;

  // While owning, last_winner is the owner, so starting at last_winner+1
  // serves both the idle search and the re-arbitration that puts the owner
  // last.
  always_comb begin
    pick_start = (last_winner_q == IDX_LAST) ? '0 : last_winner_q + IDX_W'(1);
  end

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_pick (
    .req    (req),
    .start  (pick_start),
    .valid  (pick_valid),
    .winner (pick_idx),
    .onehot (pick_onehot)
  );

  always_comb begin
    owner_req   = |(grant_q & req);
    release_own = ~owner_req | (push & (burst_cnt_q == BURST_LAST));

    state_d       = state_q;
    grant_d       = grant_q;
    burst_cnt_d   = burst_cnt_q;
    last_winner_d = last_winner_q;

    unique case (state_q)
      IDLE: begin
        if (pick_valid) begin
          state_d       = OWN;
          grant_d       = pick_onehot;
          burst_cnt_d   = '0;
          last_winner_d = pick_idx;
        end
      end
      OWN: begin
        if (release_own) begin
          burst_cnt_d = '0;
          if (pick_valid) begin
            grant_d       = pick_onehot;
            last_winner_d = pick_idx;
          end else begin
            state_d = IDLE;
            grant_d = '0;
          end
        end else if (push) begin
          burst_cnt_d = burst_cnt_q + BURST_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      grant_q       <= '0;
      burst_cnt_q   <= '0;
      last_winner_q <= IDX_LAST;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      burst_cnt_q   <= burst_cnt_d;
      last_winner_q <= last_winner_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fifo_push_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fifo_push_arbiter
//  Description : Self-checking bench for fifo_push_arbiter. A behavioural
//                reference model predicts grant/ack/push/wdata for every
//                cycle; predictions are queued as stimulus is driven and
//                compared when the outputs are sampled.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_push_arbiter;

  localparam int NUM_REQ   = 2;
  localparam int DATA_W    = 8;
  localparam int MAX_BURST = 4;

  logic                      clk;
  logic                      rst;
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic                      full;
  logic                      push;
  logic [DATA_W-1:0]         wdata;
  logic [NUM_REQ-1:0]        ack;
  logic [NUM_REQ-1:0]        grant;

  fifo_push_arbiter #(
    .NUM_REQ   (NUM_REQ),
    .DATA_W    (DATA_W),
    .MAX_BURST (MAX_BURST)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .req_data (req_data),
    .full     (full),
    .push     (push),
    .wdata    (wdata),
    .ack      (ack),
    .grant    (grant)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [NUM_REQ-1:0] grant;
    logic [NUM_REQ-1:0] ack;
    logic               push;
    logic [DATA_W-1:0]  wdata;
  } exp_t;

  exp_t sb_q[$];

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state: owner -1 means idle
  int m_owner;
  int m_cnt;
  int m_last;

  int          n_push_obs;
  logic [DATA_W-1:0]         last_wdata;
  logic [NUM_REQ*DATA_W-1:0] last_req_data;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int rr_search(input logic [NUM_REQ-1:0] r, input int from);
    for (int k = 0; k < NUM_REQ; k++) begin
      if (r[(from + k) % NUM_REQ]) return (from + k) % NUM_REQ;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_owner = -1;
    m_cnt   = 0;
    m_last  = NUM_REQ - 1;
  endtask

  // One clock cycle: drive inputs, predict, sample at negedge, advance model.
  task automatic run_cycle(input logic [NUM_REQ-1:0] r, input logic f, input logic rs);
    exp_t e;
    exp_t got;
    int   w;
    logic acked;
    req      = r;
    full     = f;
    rst      = rs;
    req_data = (NUM_REQ*DATA_W)'($urandom);

    e.grant = '0;
    e.ack   = '0;
    e.wdata = '0;
    if (m_owner >= 0) e.grant[m_owner] = 1'b1;
    if (!rs && !f && m_owner >= 0 && r[m_owner]) begin
      e.ack[m_owner] = 1'b1;
      e.wdata = req_data[m_owner*DATA_W +: DATA_W];
    end
    e.push = (e.ack != '0);
    sb_q.push_back(e);

    @(negedge clk);
    got = sb_q.pop_front();
    check_eq("grant", 32'(grant), 32'(got.grant));
    check_eq("ack",   32'(ack),   32'(got.ack));
    check_eq("push",  32'(push),  32'(got.push));
    check_eq("wdata", 32'(wdata), 32'(got.wdata));
    if (push === 1'b1) n_push_obs++;
    last_wdata    = wdata;
    last_req_data = req_data;

    acked = e.push;
    if (rs) begin
      model_reset();
    end else if (m_owner < 0) begin
      w = rr_search(r, (m_last + 1) % NUM_REQ);
      if (w >= 0) begin
        m_owner = w;
        m_cnt   = 0;
        m_last  = w;
      end
    end else begin
      if (acked) m_cnt++;
      if (!r[m_owner] || (acked && m_cnt == MAX_BURST)) begin
        w = rr_search(r, (m_owner + 1) % NUM_REQ);
        m_cnt = 0;
        if (w >= 0) begin
          m_owner = w;
          m_last  = w;
        end else begin
          m_owner = -1;
        end
      end
    end

    @(posedge clk);
    #1;
  endtask

  task automatic repeat_cycles(input int n, input logic [NUM_REQ-1:0] r, input logic f);
    for (int i = 0; i < n; i++) run_cycle(r, f, 1'b0);
  endtask

  initial begin
    rst      = 1'b1;
    req      = '0;
    req_data = '0;
    full     = 1'b0;
    n_push_obs = 0;
    // Bring the DUT out of its unknown power-up state before checking.
    @(posedge clk);
    #1;
    model_reset();

    // Reset outputs and reset mid-burst
    run_cycle(2'b00, 1'b0, 1'b1);
    run_cycle(2'b11, 1'b0, 1'b1);
    repeat_cycles(3, 2'b11, 1'b0);          // idle->grant0, two acks
    run_cycle(2'b11, 1'b0, 1'b1);           // reset in the middle of the burst
    check_eq("t1_grant_after_rst", 32'(grant), 32'(0));
    repeat_cycles(3, 2'b11, 1'b0);          // requester 0 wins first again

    // Single producer: 8 words in 8 consecutive cycles, no bubble
    run_cycle(2'b00, 1'b0, 1'b1);
    run_cycle(2'b01, 1'b0, 1'b0);           // arbitration cycle
    n_push_obs = 0;
    repeat_cycles(8, 2'b01, 1'b0);
    check_eq("t2_words", 32'(n_push_obs), 32'(8));
    check_eq("t2_grant", 32'(grant), 32'(2'b01));

    // Contention: alternate bursts of four
    run_cycle(2'b00, 1'b0, 1'b1);
    repeat_cycles(13, 2'b11, 1'b0);

    // Full stall with owner 1 after two acks
    run_cycle(2'b00, 1'b0, 1'b1);
    repeat_cycles(3, 2'b10, 1'b0);          // grant 1, two acks
    repeat_cycles(5, 2'b11, 1'b1);          // stalled
    check_eq("t4_grant_held", 32'(grant), 32'(2'b10));
    n_push_obs = 0;
    repeat_cycles(2, 2'b11, 1'b0);          // remaining two acks
    check_eq("t4_two_more", 32'(n_push_obs), 32'(2));
    check_eq("t4_rotate", 32'(grant), 32'(2'b01));
    repeat_cycles(2, 2'b11, 1'b0);

    // Early drop: owner 0 drops after one ack
    run_cycle(2'b00, 1'b0, 1'b1);
    repeat_cycles(2, 2'b11, 1'b0);          // grant 0, one ack
    repeat_cycles(5, 2'b10, 1'b0);

    // Idle return then new request from producer 1
    repeat_cycles(2, 2'b00, 1'b0);
    check_eq("t6_idle", 32'(grant), 32'(0));
    repeat_cycles(2, 2'b10, 1'b0);
    check_eq("t6_wdata", 32'(last_wdata), 32'(last_req_data[15:8]));

    // Random traffic with occasional full and reset
    for (int i = 0; i < 300; i++) begin
      run_cycle(NUM_REQ'($urandom), ($urandom_range(0, 3) == 0),
                ($urandom_range(0, 49) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fifo_push_arbiter.md
Name: fifo_push_arbiter

Overview:
- Round-robin arbiter that shares the single FIFO write port (push/data) between NUM_REQ producers.
- Sits between the producers and the FIFO pointer/memory block. Consumes that block's `full` flag and drives its `push` input and write data.
- Grants are sticky for bursts of up to MAX_BURST pushes, then rotate. Pushes into a full FIFO are never issued.

Parameters:
- NUM_REQ, 2, number of producers sharing the write port (2..8).
- DATA_W, 8, width of each producer's write data.
- MAX_BURST, 4, maximum consecutive pushes per grant before forced rotation (>=1).

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- req  input  NUM_REQ  per-producer request; held high while the producer has data.
- req_data  input  NUM_REQ*DATA_W  packed data, producer i in slice [i*DATA_W +: DATA_W].
- full  input  1  FIFO full flag from the pointer block.
- push  output  1  write strobe to the FIFO.
- wdata  output  DATA_W  write data to the FIFO.
- ack  output  NUM_REQ  one-hot; data of producer i accepted this cycle.
- grant  output  NUM_REQ  one-hot registered current owner; all zero when idle.

Behaviour:
- Clock and reset: one clock `clk`. Reset `rst` is synchronous and active-high, sampled on the rising edge of `clk`.
- Reset values:
  - state=IDLE, grant=0, burst_cnt=0, last_winner=NUM_REQ-1 (so requester 0 wins first).
  - push=0, ack=0, wdata=0.
  - Reset mid-burst aborts the grant on the next edge. No push is issued in the reset cycle.
- Combinational outputs:
  - ack = grant & req & {NUM_REQ{~full}}
  - push = |ack
  - wdata = req_data slice of the granted index when push=1, else 0.
- State IDLE:
  - If |req, the next winner is the first requester with req=1 searching from last_winner+1 upward, modulo NUM_REQ.
  - Next cycle: grant=onehot(winner), burst_cnt=0, state=OWN, last_winner=winner.
  - Latency: req high at edge t -> grant and ack at cycle t+1, provided full=0.
- State OWN:
  - On each ack, burst_cnt increments.
  - While full=1: no ack, burst_cnt holds, grant holds. Full never causes rotation.
  - Release condition (evaluated each cycle): the owner's req=0, OR (ack=1 AND burst_cnt==MAX_BURST-1).
  - On release: re-arbitrate in the same cycle, searching from owner+1 and including the owner last.
    - Winner found: grant switches next edge with no bubble; burst_cnt=0; last_winner=winner.
    - No winner: grant=0, state=IDLE.
  - A sole remaining requester that exhausts its burst is re-granted immediately, with burst_cnt cleared.
- Widths:
  - burst_cnt width = $clog2(MAX_BURST+1).
  - Index width = $clog2(NUM_REQ), minimum 1.
  - Modulo wrap from NUM_REQ-1 to 0.
- Invariants:
  - grant and ack are one-hot or zero.
  - ack is never high while full=1.
  - At most MAX_BURST consecutive acks per grant.
  - A continuously requesting producer waits at most (NUM_REQ-1)*MAX_BURST pushes.
- A producer dropping req mid-burst forfeits the rest of its burst and loses no data. Its last accepted word is the last ack.

Decomposition:
- fifo_pkg additions:
  - arb_state_e {IDLE, OWN}
  - constants NUM_REQ, MAX_BURST, DATA_W
  - typedefs req_vec_t (logic [NUM_REQ-1:0]), req_idx_t, burst_cnt_t
  - Existing TRUE/FALSE are reused.
- Sub-module rr_pick: combinational round-robin picker.
  - Inputs: req vector, start index.
  - Outputs: valid, winner index, one-hot.
  - Used for both the IDLE grant and the OWN re-arbitration.

Test Plan:
1. Reset mid-burst: rst=1 during OWN with 2 acks done -> next cycle grant=0, push=0. After release, req=2'b11 -> requester 0 granted first.
2. Single producer: req=2'b01 held, full=0, MAX_BURST=4 -> push every cycle from t+1. Grant stays 2'b01 across the burst boundary with no bubble; 8 words in 8 consecutive cycles.
3. Contention: req=2'b11 held, full=0 -> acks 0,0,0,0,1,1,1,1,0,... with a grant switch exactly after every 4th ack and no idle cycle.
4. Full stall: owner 1 after 2 acks, full=1 for 5 cycles -> ack=0, push=0, grant=2'b10 held. After full=0, exactly 2 more acks before rotation.
5. Early drop: owner 0 drops req after 1 ack while req[1]=1 -> next cycle grant=2'b10, burst_cnt=0. Requester 0 receives no further ack.
6. Idle return: all req fall -> next cycle grant=0, state IDLE. New req=2'b10 -> grant=2'b10 one cycle later, with wdata equal to req_data[15:8].
